// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline segment: opcodes, the bubble
// instruction and the access FSM encoding.
package mem_stage_pkg;

    localparam logic [5:0]  OP_LW     = 6'h23;
    localparam logic [5:0]  OP_SW     = 6'h2B;
    localparam logic [31:0] BUBBLE_IR = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_ins_analyser.sv
// Opcode decoder shared by pipeline segments; classifies an instruction as a
// word load or word store. The all-ones bubble opcode matches neither.
module InsAnalyser
    import mem_stage_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_load,
    output logic       is_store
);

    assign is_load  = (opcode == OP_LW);
    assign is_store = (opcode == OP_SW);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline segment: latches EX results, runs word loads/stores over the
// data-memory req/ack bus and stalls the front of the pipe while busy.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] BUBBLE_IR = mem_stage_pkg::BUBBLE_IR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR_i,
    input  logic [31:0] ALUo_i,
    input  logic [31:0] B_i,
    output logic [31:0] IR_o,
    output logic [31:0] ALUo_o,
    output logic [31:0] LMD_o,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        align_err,
    output logic        bus_err
);

    localparam int             TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        state, state_d;
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   aluo_q, aluo_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   lmd_q, lmd_d;
    logic          req_d, we_d;
    logic [31:0]   addr_d;
    logic [TW-1:0] timer, timer_d;
    logic          align_d, bus_d;
    logic          is_load, is_store;
    logic          is_mem;

    InsAnalyser u_ins_analyser (
        .opcode   (IR_i[31:26]),
        .is_load  (is_load),
        .is_store (is_store)
    );

    assign is_mem = is_load | is_store;

    always_comb begin
        state_d = state;
        ir_d    = ir_q;
        aluo_d  = aluo_q;
        b_d     = b_q;
        lmd_d   = lmd_q;
        req_d   = dmem_req;
        we_d    = dmem_we;
        addr_d  = dmem_addr;
        timer_d = timer;
        align_d = 1'b0;
        bus_d   = 1'b0;

        unique case (state)
            IDLE: begin
                if (!is_mem) begin
                    ir_d   = IR_i;
                    aluo_d = ALUo_i;
                    b_d    = B_i;
                    lmd_d  = '0;
                end else if (ALUo_i[1:0] != 2'b00) begin
                    ir_d    = BUBBLE_IR;
                    lmd_d   = '0;
                    align_d = 1'b1;
                end else begin
                    ir_d    = IR_i;
                    aluo_d  = ALUo_i;
                    b_d     = B_i;
                    lmd_d   = '0;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {ALUo_i[31:2], 2'b00};
                    timer_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // An ack arriving on the final timer cycle still counts as success.
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!dmem_we) begin
                        lmd_d = dmem_rdata;
                    end
                    state_d = IDLE;
                end else if (timer == TIMER_LAST) begin
                    req_d   = 1'b0;
                    ir_d    = BUBBLE_IR;
                    bus_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            ir_q      <= BUBBLE_IR;
            aluo_q    <= '0;
            b_q       <= '0;
            lmd_q     <= '0;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            dmem_addr <= '0;
            timer     <= '0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            aluo_q    <= aluo_d;
            b_q       <= b_d;
            lmd_q     <= lmd_d;
            dmem_req  <= req_d;
            dmem_we   <= we_d;
            dmem_addr <= addr_d;
            timer     <= timer_d;
            align_err <= align_d;
            bus_err   <= bus_d;
        end
    end

    // Store data is the latched rt value; the stage registers hold while BUSY,
    // so the bus sees stable write data for the whole access.
    assign dmem_wdata = b_q;

    assign mem_stall = (state == BUSY);
    assign IR_o      = (state == BUSY) ? BUBBLE_IR : ir_q;
    assign ALUo_o    = aluo_q;
    assign LMD_o     = lmd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed steps push expected outputs, a
// posedge monitor pops and compares them against the falling-edge design.
module tb_mem_stage;

    localparam logic [31:0] BUB = 32'hFFFF_FFFF;
    localparam logic [31:0] ADD = 32'h0022_1820;
    localparam logic [31:0] LW  = 32'h8C25_0000;
    localparam logic [31:0] SW  = 32'hAC22_0004;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic [31:0] aluo;
        logic [31:0] lmd;
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        align;
        logic        bus;
    } exp_t;

    logic        clk = 1'b1;
    logic        rst;
    logic [31:0] ir_i, aluo_i, b_i, rdata;
    logic        ack;
    logic [31:0] ir_o, aluo_o, lmd_o, addr, wdata;
    logic        stall, req, we, align_err, bus_err;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .IR_i       (ir_i),
        .ALUo_i     (aluo_i),
        .B_i        (b_i),
        .IR_o       (ir_o),
        .ALUo_o     (aluo_o),
        .LMD_o      (lmd_o),
        .mem_stall  (stall),
        .dmem_req   (req),
        .dmem_we    (we),
        .dmem_addr  (addr),
        .dmem_wdata (wdata),
        .dmem_rdata (rdata),
        .dmem_ack   (ack),
        .align_err  (align_err),
        .bus_err    (bus_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] aluo, input logic [31:0] b,
                                 input logic a, input logic [31:0] rd);
        ir_i   = ir;
        aluo_i = aluo;
        b_i    = b;
        ack    = a;
        rdata  = rd;
    endtask

    // Queue the outputs expected after the coming falling edge, then advance one cycle.
    task automatic expect_step(input string name, input logic [31:0] ir, input logic [31:0] aluo,
                               input logic [31:0] lmd, input logic st, input logic rq, input logic w,
                               input logic [31:0] ad, input logic [31:0] wd, input logic al, input logic be);
        exp_t x;
        x.name = name; x.ir = ir; x.aluo = aluo; x.lmd = lmd; x.stall = st; x.req = rq;
        x.we = w; x.addr = ad; x.wdata = wd; x.align = al; x.bus = be;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput($sformatf("%s.ir", e.name),    ir_o,            e.ir);
            checkOutput($sformatf("%s.aluo", e.name),  aluo_o,          e.aluo);
            checkOutput($sformatf("%s.lmd", e.name),   lmd_o,           e.lmd);
            checkOutput($sformatf("%s.stall", e.name), 32'(stall),      32'(e.stall));
            checkOutput($sformatf("%s.req", e.name),   32'(req),        32'(e.req));
            checkOutput($sformatf("%s.align", e.name), 32'(align_err),  32'(e.align));
            checkOutput($sformatf("%s.bus", e.name),   32'(bus_err),    32'(e.bus));
            if (e.req) begin
                checkOutput($sformatf("%s.we", e.name),   32'(we), 32'(e.we));
                checkOutput($sformatf("%s.addr", e.name), addr,    e.addr);
                if (e.we) begin
                    checkOutput($sformatf("%s.wdata", e.name), wdata, e.wdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        applyStimulus(BUB, 32'h0, 32'h0, 1'b0, 32'h0);
        expect_step("reset", BUB, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        rst = 1'b1;

        applyStimulus(ADD, 32'h5, 32'h77, 1'b0, 32'h0);
        expect_step("alu_op", ADD, 32'h5, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        applyStimulus(LW, 32'h100, 32'h55, 1'b0, 32'h0);
        expect_step("lw_issue", BUB, 32'h100, 32'h0, 1, 1, 0, 32'h100, 32'h0, 0, 0);
        expect_step("lw_wait", BUB, 32'h100, 32'h0, 1, 1, 0, 32'h100, 32'h0, 0, 0);
        applyStimulus(LW, 32'h100, 32'h55, 1'b1, 32'hDEAD_BEEF);
        expect_step("lw_ack", LW, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        applyStimulus(SW, 32'h204, 32'h1234, 1'b0, 32'h0);
        expect_step("sw_issue", BUB, 32'h204, 32'h0, 1, 1, 1, 32'h204, 32'h1234, 0, 0);
        applyStimulus(SW, 32'h204, 32'h1234, 1'b1, 32'hBAD0_BAD0);
        expect_step("sw_ack", SW, 32'h204, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        applyStimulus(LW, 32'h102, 32'h0, 1'b0, 32'h0);
        expect_step("misalign", BUB, 32'h204, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
        applyStimulus(ADD, 32'h9, 32'h0, 1'b1, 32'h1111);
        expect_step("idle_ack", ADD, 32'h9, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        applyStimulus(LW, 32'h300, 32'h0, 1'b0, 32'h0);
        expect_step("to_issue", BUB, 32'h300, 32'h0, 1, 1, 0, 32'h300, 32'h0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            expect_step($sformatf("to_wait%0d", i), BUB, 32'h300, 32'h0, 1, 1, 0, 32'h300, 32'h0, 0, 0);
        end
        expect_step("to_abort", BUB, 32'h300, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1);
        applyStimulus(ADD, 32'hA, 32'h0, 1'b1, 32'h2222);
        expect_step("late_ack", ADD, 32'hA, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        applyStimulus(LW, 32'h400, 32'h0, 1'b0, 32'h0);
        expect_step("edge_issue", BUB, 32'h400, 32'h0, 1, 1, 0, 32'h400, 32'h0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            expect_step($sformatf("edge_wait%0d", i), BUB, 32'h400, 32'h0, 1, 1, 0, 32'h400, 32'h0, 0, 0);
        end
        applyStimulus(LW, 32'h400, 32'h0, 1'b1, 32'hCAFE_F00D);
        expect_step("edge_ack", LW, 32'h400, 32'hCAFE_F00D, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        applyStimulus(LW, 32'h500, 32'h0, 1'b0, 32'h0);
        expect_step("rst_issue", BUB, 32'h500, 32'h0, 1, 1, 0, 32'h500, 32'h0, 0, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_async.req", 32'(req), 32'h0);
        checkOutput("rst_async.stall", 32'(stall), 32'h0);
        checkOutput("rst_async.ir", ir_o, BUB);
        applyStimulus(LW, 32'h500, 32'h0, 1'b1, 32'h3333);
        expect_step("rst_hold", BUB, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        rst = 1'b1;
        applyStimulus(ADD, 32'h5, 32'h0, 1'b1, 32'h4444);
        expect_step("post_rst", ADD, 32'h5, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        applyStimulus(BUB, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
